qnigma_alu_seq: RTL and testbench
=================================

QNIGMA_ALU_SEQ -- requirements
Module: qnigma_alu_seq

Interface
REQ-001 Parameter PC_W, default 6, program-counter width (program depth 2^PC_W).
REQ-002 Parameter TMO_CYC, default 4095, maximum cycles allowed for one ALU task before timeout.
REQ-003 Port clk  in  1  clock; all logic rising-edge.
REQ-004 Port rst  in  1  reset; synchronous, active-high.
REQ-005 Port start  in  1  one-cycle pulse; begin a program at entry; ignored unless idle.
REQ-006 Port entry  in  PC_W  first instruction address; sampled with start.
REQ-007 Port prog_addr  out  PC_W  program memory read address.
REQ-008 Port prog_dat  in  seq_ins_t  instruction word; valid exactly 1 cycle after prog_addr.
REQ-009 Port task_info  out  task_t  ALU task descriptor (op_typ, pri, rd_ptr_a, rd_ptr_b, wr_ptr, cpy_src, cpy_dst).
REQ-010 Port task_valid  out  1  one-cycle task issue strobe.
REQ-011 Port task_done  in  1  ALU completion pulse.
REQ-012 Port alu_eql  in  1  ALU equality flag; valid in the cycle task_done is high.
REQ-013 Port busy  out  1  program running.
REQ-014 Port done  out  1  one-cycle pulse at normal END.
REQ-015 Port err  out  1  sticky timeout flag; cleared by the next accepted start.

Function
REQ-016 Instruction opcodes SHALL be: TSK (issue task), BEQ (branch to tgt if eql_flag set), JMP (unconditional), LDC (load loop counter with cnt), LOOP (decrement counter; branch to tgt if result nonzero), END.
REQ-017 The FSM SHALL have states IDLE, FETCH, DECODE, ISSUE, WAIT, FIN.
REQ-018 IDLE with start: pc<=entry, busy<=1, err<=0, ->FETCH; start while busy SHALL be ignored.
REQ-019 FETCH drives prog_addr=pc and ->DECODE; DECODE registers prog_dat.
REQ-020 DECODE TSK: ->ISSUE; ISSUE asserts task_valid for exactly one cycle with task_info held stable from ISSUE until WAIT exits, then ->WAIT.
REQ-021 WAIT on task_done: eql_flag<=alu_eql, pc<=pc+1, ->FETCH.
REQ-022 DECODE JMP: pc<=tgt; BEQ: pc<=eql_flag ? tgt : pc+1; both ->FETCH; no task issued.
REQ-023 DECODE LDC: cnt<=ins.cnt (8-bit), pc<=pc+1. LOOP: cnt<=cnt-1, pc<=(cnt-1!=0) ? tgt : pc+1. LOOP with cnt=0 SHALL wrap cnt to 255 and branch.
REQ-024 DECODE END: ->FIN; FIN pulses done for one cycle, busy<=0, ->IDLE.
REQ-025 pc+1 SHALL wrap modulo 2^PC_W.
REQ-026 WAIT timeout counter SHALL clear on ISSUE; reaching TMO_CYC without task_done: err<=1, busy<=0, ->IDLE, no done pulse.
REQ-027 task_done outside WAIT SHALL be ignored.
REQ-028 Task latency: task_valid SHALL occur 3 cycles after the start pulse for a TSK at entry; next fetch SHALL begin the cycle after task_done.

Reset
REQ-029 rst SHALL force state IDLE, pc=0, cnt=0, eql_flag=0, task_valid=0, busy=0, done=0, err=0, prog_addr=0, task_info=0.
REQ-030 rst mid-task SHALL abandon the program immediately; a later task_done SHALL be ignored.

Structure
REQ-031 seq_opc_t, seq_ins_t (opc, tsk:task_t, tgt, cnt) SHALL reside in qnigma_math_pkg beside task_t.
REQ-032 Single module, no sub-modules; the program memory stays external.

Verification
REQ-033 Program {TSK mul, END} at entry 5: start -> prog_addr=5, task_valid 3 cycles later, task_done after 40 cycles -> done pulse, busy low.
REQ-034 {LDC 3, TSK add, LOOP->1, END}: exactly 3 task_valid pulses, then done.
REQ-035 {TSK sub, BEQ->3, END, TSK cpy, END}: alu_eql=1 -> cpy issued; alu_eql=0 -> no further task.
REQ-036 TSK with task_done withheld: err=1 after TMO_CYC cycles, busy=0, no done; next start clears err.
REQ-037 rst asserted in WAIT, then stray task_done -> outputs stay at reset values, start accepted afterwards.

Source files
------------

// File: rtl/qnigma_math_pkg.sv
// Shared ALU task and sequencer instruction types.
// Imported by the ALU sequencer and its neighbours.
package qnigma_math_pkg;

    localparam int PTR_W = 4;
    localparam int SEQ_TGT_W = 8;
    localparam int SEQ_CNT_W = 8;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_MUL,
        ALU_CPY
    } alu_op_t;

    typedef struct packed {
        alu_op_t          op_typ;
        logic [1:0]       pri;
        logic [PTR_W-1:0] rd_ptr_a;
        logic [PTR_W-1:0] rd_ptr_b;
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] cpy_src;
        logic [PTR_W-1:0] cpy_dst;
    } task_t;

    typedef enum logic [2:0] {
        OPC_TSK,
        OPC_BEQ,
        OPC_JMP,
        OPC_LDC,
        OPC_LOOP,
        OPC_END
    } seq_opc_t;

    typedef struct packed {
        seq_opc_t             opc;
        task_t                tsk;
        logic [SEQ_TGT_W-1:0] tgt;
        logic [SEQ_CNT_W-1:0] cnt;
    } seq_ins_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_FIN
    } seq_state_t;

endpackage

// File: rtl/qnigma_alu_seq.sv
// Micro-sequencer: walks an external program and issues ALU tasks.
// Supports task issue, branches, and an 8-bit hardware loop counter.
module qnigma_alu_seq
    import qnigma_math_pkg::*;
#(
    parameter int PC_W    = 6,
    parameter int TMO_CYC = 4095
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [PC_W-1:0] entry,
    output logic [PC_W-1:0] prog_addr,
    input  seq_ins_t        prog_dat,
    output task_t           task_info,
    output logic            task_valid,
    input  logic            task_done,
    input  logic            alu_eql,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int TW = $clog2(TMO_CYC + 1);

    seq_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc, tgt;
    logic [7:0]      cnt_q, cnt_d, cnt_dec;
    logic            eql_q, eql_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    task_t           task_q, task_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    assign pc_inc  = pc_q + 1'b1;
    assign cnt_dec = cnt_q - 8'd1;
    assign tgt     = prog_dat.tgt[PC_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            eql_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            task_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            eql_q   <= eql_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            task_q  <= task_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        eql_d   = eql_q;
        busy_d  = busy_q;
        err_d   = err_q;
        task_d  = task_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = entry;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_FETCH;
                case (prog_dat.opc)
                    OPC_TSK: begin
                        task_d  = prog_dat.tsk;
                        state_d = S_ISSUE;
                    end
                    OPC_JMP: pc_d = tgt;
                    OPC_BEQ: pc_d = eql_q ? tgt : pc_inc;
                    OPC_LDC: begin
                        cnt_d = prog_dat.cnt;
                        pc_d  = pc_inc;
                    end
                    OPC_LOOP: begin
                        cnt_d = cnt_dec;
                        pc_d  = (cnt_dec != 8'd0) ? tgt : pc_inc;
                    end
                    // unknown opcodes terminate like END
                    default: state_d = S_FIN;
                endcase
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (task_done) begin
                    eql_d   = alu_eql;
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end else if (tmo_q == TW'(TMO_CYC - 1)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign prog_addr  = pc_q;
    assign task_info  = task_q;
    assign task_valid = (state_q == S_ISSUE);
    assign done       = (state_q == S_FIN);
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_qnigma_alu_seq.sv
// Directed bench for qnigma_alu_seq with a task scoreboard.
// A background responder plays the ALU and the program memory.
module tb_qnigma_alu_seq;
    import qnigma_math_pkg::*;

    localparam int PC_W = 6;
    localparam int TMO  = 60;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [PC_W-1:0] entry = '0;
    logic [PC_W-1:0] prog_addr;
    seq_ins_t        prog_dat;
    task_t           task_info;
    logic            task_valid;
    logic            task_done = 1'b0;
    logic            alu_eql = 1'b0;
    logic            busy, done, err;

    seq_ins_t mem [64];
    task_t    exp_q[$];
    task_t    obs_q[$];

    int checks = 0;
    int failures = 0;

    int cyc = 0, start_cyc = -10, first_tv = -1, tv_cyc = -10;
    int td_cyc = -10, err_cyc = -1, tv_cnt = 0, done_cnt = 0, pend = 0;
    logic [PC_W-1:0] fetch_addr = '0, nf_addr = '0;
    int  resp_lat = 5;
    bit  resp_en = 1'b1;
    bit  resp_eql = 1'b0;
    int  stray_req = 0, stray_ack = 0;

    qnigma_alu_seq #(.PC_W(PC_W), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .entry(entry),
        .prog_addr(prog_addr), .prog_dat(prog_dat),
        .task_info(task_info), .task_valid(task_valid),
        .task_done(task_done), .alu_eql(alu_eql),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) prog_dat <= mem[prog_addr];

    // ALU responder and observer, active on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            task_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    task_done = 1'b1;
                    alu_eql = resp_eql;
                    td_cyc = cyc;
                end
            end
            if (stray_req != stray_ack) begin
                stray_ack = stray_req;
                task_done = 1'b1;
            end
            if (start) begin
                start_cyc = cyc;
                first_tv = -1;
                err_cyc = -1;
            end
            if (cyc == start_cyc + 1) fetch_addr = prog_addr;
            if (cyc == td_cyc + 1) nf_addr = prog_addr;
            if (task_valid) begin
                obs_q.push_back(task_info);
                tv_cnt++;
                if (first_tv < 0) first_tv = cyc;
                tv_cyc = cyc;
                if (resp_en) pend = resp_lat;
            end
            if (done) done_cnt++;
            if (err && err_cyc < 0) err_cyc = cyc;
            if (rst) pend = 0;
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int e);
        entry = PC_W'(e);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (!busy) break;
            tick(1);
        end
        chk({tag, "_bound"}, longint'(i < bound), 1);
        tick(2);
    endtask

    task automatic drain(input string tag);
        task_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) chk({tag, "_miss"}, obs_q.size(), 1);
            else chk(tag, longint'(obs_q.pop_front()), longint'(e));
        end
        chk({tag, "_extra"}, obs_q.size(), 0);
    endtask

    function automatic task_t mkt(input alu_op_t op, input logic [3:0] b);
        task_t t;
        t.op_typ   = op;
        t.pri      = b[1:0];
        t.rd_ptr_a = b;
        t.rd_ptr_b = b + 4'd1;
        t.wr_ptr   = b + 4'd2;
        t.cpy_src  = b + 4'd3;
        t.cpy_dst  = b + 4'd4;
        return t;
    endfunction

    function automatic seq_ins_t mki(input seq_opc_t o, input task_t t,
                                     input int tg, input int c);
        seq_ins_t r;
        r.opc = o;
        r.tsk = t;
        r.tgt = 8'(tg);
        r.cnt = 8'(c);
        return r;
    endfunction

    initial begin
        int tv0, dn0;
        task_t t_mul, t_add, t_sub, t_cpy;
        t_mul = mkt(ALU_MUL, 4'h1);
        t_add = mkt(ALU_ADD, 4'h2);
        t_sub = mkt(ALU_SUB, 4'h3);
        t_cpy = mkt(ALU_CPY, 4'h5);
        for (int i = 0; i < 64; i++) mem[i] = mki(OPC_END, '0, 0, 0);
        mem[5]  = mki(OPC_TSK, t_mul, 0, 0);
        mem[10] = mki(OPC_LDC, '0, 0, 3);
        mem[11] = mki(OPC_TSK, t_add, 0, 0);
        mem[12] = mki(OPC_LOOP, '0, 11, 0);
        mem[20] = mki(OPC_LDC, '0, 0, 0);
        mem[21] = mki(OPC_LOOP, '0, 23, 0);
        mem[23] = mki(OPC_TSK, t_cpy, 0, 0);
        mem[30] = mki(OPC_TSK, t_sub, 0, 0);
        mem[31] = mki(OPC_BEQ, '0, 33, 0);
        mem[33] = mki(OPC_TSK, t_cpy, 0, 0);
        mem[40] = mki(OPC_JMP, '0, 45, 0);
        mem[41] = mki(OPC_TSK, t_mul, 0, 0);
        mem[45] = mki(OPC_TSK, t_add, 0, 0);
        mem[63] = mki(OPC_TSK, t_sub, 0, 0);

        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_tv", task_valid, 0);
        chk("rst_addr", prog_addr, 0);
        chk("rst_info", longint'(task_info), 0);

        // single task, entry 5, 40-cycle ALU
        resp_lat = 40;
        tv0 = tv_cnt; dn0 = done_cnt;
        exp_q.push_back(t_mul);
        pulse_start(5);
        chk("t1_busy", busy, 1);
        wait_idle("t1", 200);
        chk("t1_fetch", fetch_addr, 5);
        chk("t1_lat", first_tv - start_cyc, 3);
        chk("t1_nf", nf_addr, 6);
        chk("t1_tv", tv_cnt - tv0, 1);
        chk("t1_done", done_cnt - dn0, 1);
        chk("t1_busy_lo", busy, 0);
        drain("t1_sb");

        // counted loop of three adds
        resp_lat = 5;
        tv0 = tv_cnt; dn0 = done_cnt;
        repeat (3) exp_q.push_back(t_add);
        pulse_start(10);
        wait_idle("t2", 200);
        chk("t2_tv", tv_cnt - tv0, 3);
        chk("t2_done", done_cnt - dn0, 1);
        drain("t2_sb");

        // LOOP on a zero counter wraps and branches
        tv0 = tv_cnt;
        exp_q.push_back(t_cpy);
        pulse_start(20);
        wait_idle("t3", 200);
        chk("t3_tv", tv_cnt - tv0, 1);
        drain("t3_sb");

        // BEQ taken
        resp_eql = 1'b1;
        tv0 = tv_cnt;
        exp_q.push_back(t_sub);
        exp_q.push_back(t_cpy);
        pulse_start(30);
        wait_idle("t4", 200);
        chk("t4_tv", tv_cnt - tv0, 2);
        drain("t4_sb");

        // BEQ not taken
        resp_eql = 1'b0;
        tv0 = tv_cnt; dn0 = done_cnt;
        exp_q.push_back(t_sub);
        pulse_start(30);
        wait_idle("t5", 200);
        chk("t5_tv", tv_cnt - tv0, 1);
        chk("t5_done", done_cnt - dn0, 1);
        drain("t5_sb");

        // JMP skips the intervening task
        tv0 = tv_cnt;
        exp_q.push_back(t_add);
        pulse_start(40);
        wait_idle("t6", 200);
        chk("t6_tv", tv_cnt - tv0, 1);
        drain("t6_sb");

        // pc wraps from 63 to 0
        tv0 = tv_cnt; dn0 = done_cnt;
        exp_q.push_back(t_sub);
        pulse_start(63);
        wait_idle("t7", 200);
        chk("t7_nf", nf_addr, 0);
        chk("t7_done", done_cnt - dn0, 1);
        drain("t7_sb");

        // timeout, with a start ignored mid-wait
        resp_en = 1'b0;
        tv0 = tv_cnt; dn0 = done_cnt;
        exp_q.push_back(t_mul);
        pulse_start(5);
        tick(8);
        pulse_start(40);
        wait_idle("t8", TMO + 50);
        chk("t8_err", err, 1);
        chk("t8_tmo", err_cyc - tv_cyc, TMO + 1);
        chk("t8_busy", busy, 0);
        chk("t8_done", done_cnt - dn0, 0);
        chk("t8_tv", tv_cnt - tv0, 1);
        drain("t8_sb");

        // next start clears err
        resp_en = 1'b1;
        dn0 = done_cnt;
        exp_q.push_back(t_mul);
        pulse_start(5);
        chk("t9_err_clr", err, 0);
        wait_idle("t9", 200);
        chk("t9_done", done_cnt - dn0, 1);
        drain("t9_sb");

        // reset in WAIT, then a stray completion
        resp_en = 1'b0;
        tv0 = tv_cnt; dn0 = done_cnt;
        exp_q.push_back(t_mul);
        pulse_start(5);
        tick(6);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        stray_req++;
        tick(4);
        chk("t10_busy", busy, 0);
        chk("t10_err", err, 0);
        chk("t10_addr", prog_addr, 0);
        chk("t10_info", longint'(task_info), 0);
        chk("t10_tv", tv_cnt - tv0, 1);
        chk("t10_done", done_cnt - dn0, 0);
        drain("t10_sb");

        resp_en = 1'b1;
        dn0 = done_cnt;
        exp_q.push_back(t_sub);
        pulse_start(63);
        wait_idle("t11", 200);
        chk("t11_done", done_cnt - dn0, 1);
        drain("t11_sb");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
